sinc_down_timer: RTL
====================

Name: sinc_down_timer

Overview:
Synchronous loadable down-counter and timer. It is the count-down counterpart of the team's up-counter.
- Software or an FSM loads a start value; the block decrements it to zero while enabled.
- Reaching zero produces a one-cycle terminal-count pulse.
- Optional auto-reload gives a periodic tick generator with period = loaded value, in enabled cycles.
- Used for timeouts, baud/tick dividers and delay generation alongside the up-counter.

Parameters:
WIDTH, 8, bit width of count and load value.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
enable  input  1  count enable; 1 = decrement on this edge, 0 = hold count.
load  input  1  load strobe; captures load_value on this edge.
load_value  input  WIDTH  start/reload value.
auto_reload  input  1  1 = restart from stored reload value on terminal count; 0 = stop in IDLE.
out  output  WIDTH  current count, registered.
tc  output  1  terminal-count pulse, registered, one cycle.
busy  output  1  1 while in RUN state.

Behaviour:
- Internal state: 2-state FSM {IDLE, RUN}; reload register rl[WIDTH-1:0].
- Reset (reset=1 at edge) has highest priority. Next cycle: state=IDLE, out=0, rl=0, tc=0, busy=0. Applies mid-count too; load and enable are ignored that edge.
- tc defaults to 0 every edge unless set by a rule below, so it is never high for two consecutive cycles except on consecutive terminal events.
- Load has priority over enable, in any state. Effects on that edge:
  - rl <= load_value; out <= load_value.
  - If load_value != 0: state <= RUN.
  - If load_value == 0: state <= IDLE, tc <= 1 (immediate expiry).
- IDLE, load=0: out holds; enable ignored; busy=0.
- RUN, load=0, enable=0: out holds (pause); no tc.
- RUN, load=0, enable=1:
  - out > 1: out <= out - 1.
  - out == 1: tc <= 1 (tc is high in the cycle following the decrement edge).
    - auto_reload=1: out <= rl, stay RUN. rl != 0 is guaranteed because RUN is only entered with a non-zero value.
    - auto_reload=0: out <= 0, state <= IDLE.
- busy = (state == RUN), registered with the state.
- Timing, one-shot: load N (N≥1) with enable held high. tc is asserted exactly N edges after the load edge, and out==0 in that same cycle.
- Timing, auto-reload: tc repeats every rl enabled edges.
- auto_reload is sampled only at the out==1 decrement edge; changing it mid-count has no other effect.
- No wrap-around below zero: out never decrements from 0. RUN with out==0 is unreachable.
- A load arriving on the same edge as a terminal decrement wins: new value loaded, tc not asserted.

Decomposition:
- Shared package sinc_timer_pkg: state encoding constants (ST_IDLE=1'b0, ST_RUN=1'b1) and the default WIDTH constant.
- No sub-module: a single always block for FSM/count/rl plus registered tc/busy.
- The existing up-counter is not instantiated.

Test Plan:
1. Reset mid-run: load 10, enable=1 for 3 cycles (out=7), assert reset one edge -> out=0, busy=0, tc=0 next cycle; enable with no load keeps out=0.
2. One-shot: load 5, auto_reload=0, enable=1 -> out 5,4,3,2,1,0; tc=1 only in the out=0 cycle; busy falls in the same cycle; out stays 0.
3. Pause: load 4, enable pattern 1,0,0,1,1,1 -> out 4,3,3,3,2,1,0; tc exactly once at 0.
4. Auto-reload: load 3, auto_reload=1, enable=1 for 9 edges -> out 3,2,1,3,2,1,3,2,1,3; tc high in each cycle out returns to 3 (period 3); busy stays 1.
5. Load 0: load_value=0 -> out=0, tc=1 one cycle, busy=0; WIDTH max load 8'hFF runs 255 edges to tc.
6. Collision: load 6 counting down, at out=1 assert load with load_value=9 and enable=1 -> out=9, tc=0, stays RUN.

Source files
------------

// File: rtl/sinc_timer_pkg.sv
// Shared definitions for the sinc timer family: FSM state encoding and default width.
package sinc_timer_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sinc_down_timer.sv
// Loadable down-counter/timer: counts a loaded value to zero while enabled, pulses tc
// on expiry and optionally restarts from the stored reload value for periodic ticks.
module sinc_down_timer
    import sinc_timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] rl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            out   <= '0;
            rl    <= '0;
            tc    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                // Load wins over a coincident terminal decrement, so no tc from that path.
                rl  <= load_value;
                out <= load_value;
                if (load_value != '0) begin
                    state <= ST_RUN;
                    busy  <= 1'b1;
                end else begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    tc    <= 1'b1;
                end
            end else if (state == ST_RUN && enable) begin
                if (out > WIDTH'(1)) begin
                    out <= out - WIDTH'(1);
                end else begin
                    // out==1 here; RUN is only entered with a non-zero count.
                    tc <= 1'b1;
                    if (auto_reload) begin
                        out <= rl;
                    end else begin
                        out   <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
